// File: rtl/wbxbc_syscon_pkg.sv
// Shared types and width helpers for the WbXbc SYSCON reset/clock-enable sequencer.
package wbxbc_syscon_pkg;

   typedef enum logic [1:0] {
      RESET,
      POR,
      RELEASE,
      RUN
   } syscon_state_e;

   // Width of a counter holding 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/wb_syscon_div.sv
// One clock-enable divider channel: a reloading down-counter that emits a registered
// one-cycle pulse every div_i+1 cycles while the domain is enabled and out of reset.
module wb_syscon_div
   import wbxbc_syscon_pkg::*;
#(
   parameter int DIV_WIDTH = 8
) (
   input  logic                 clk_i,
   input  logic                 sync_rst_i,
   input  logic                 hold_i,
   input  logic                 en_i,
   input  logic [DIV_WIDTH-1:0] div_i,
   output logic                 sync_o
);

   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
   logic                 sync_q, sync_d;

   // hold_i is the domain reset as it will be after this edge, so a pulse never
   // coincides with an asserted reset and the first pulse after release is immediate.
   always_comb begin
      cnt_d  = cnt_q;
      sync_d = 1'b0;
      if (hold_i || !en_i) begin
         cnt_d = '0;
      end else if (cnt_q == '0) begin
         sync_d = 1'b1;
         cnt_d  = div_i;
      end else begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (sync_rst_i) begin
         cnt_q  <= '0;
         sync_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sync_q <= sync_d;
      end
   end

   assign sync_o = sync_q;

endmodule

// File: rtl/wb_syscon_seq.sv
// WbXbc SYSCON: staged per-domain reset release after a power-on delay plus per-domain
// clock-enable dividers. Define WBXBC_SYSCON_FORMAL_EN to embed assertions and covers.
module wb_syscon_seq
   import wbxbc_syscon_pkg::*;
#(
   parameter int CH          = 4,
   parameter int POR_DELAY   = 8,
   parameter int STAGE_DELAY = 2,
   parameter int DIV_WIDTH   = 8
) (
   input  logic                    clk_i,
   input  logic                    sync_rst_i,
   input  logic                    soft_rst_i,
   input  logic [CH-1:0]           en_i,
   input  logic [CH*DIV_WIDTH-1:0] div_i,
   output logic [CH-1:0]           rst_o,
   output logic [CH-1:0]           sync_o,
   output logic                    ready_o
);

   localparam int POR_W = cnt_width(POR_DELAY);
   localparam int STG_W = cnt_width(STAGE_DELAY);
   localparam int IDX_W = cnt_width(CH);

   syscon_state_e    state_q, state_d;
   logic [POR_W-1:0] por_q, por_d;
   logic [STG_W-1:0] stg_q, stg_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CH-1:0]    rst_q, rst_d;

   always_ff @(posedge clk_i) begin
      if (sync_rst_i) begin
         state_q <= RESET;
         por_q   <= '0;
         stg_q   <= '0;
         idx_q   <= '0;
         rst_q   <= '1;
      end else begin
         state_q <= state_d;
         por_q   <= por_d;
         stg_q   <= stg_d;
         idx_q   <= idx_d;
         rst_q   <= rst_d;
      end
   end

   // Leaving RESET and a soft reset both restart the power-on count from zero.
   always_comb begin
      state_d = state_q;
      por_d   = por_q;
      stg_d   = stg_q;
      idx_d   = idx_q;
      rst_d   = rst_q;
      if (state_q == RESET || soft_rst_i) begin
         state_d = POR;
         por_d   = '0;
         stg_d   = '0;
         idx_d   = '0;
         rst_d   = '1;
      end else begin
         case (state_q)
            POR: begin
               if (por_q == POR_W'(POR_DELAY - 1)) begin
                  rst_d[0] = 1'b0;
                  idx_d    = IDX_W'(1);
                  stg_d    = '0;
                  if (STAGE_DELAY == 0 || CH == 1) begin
                     rst_d   = '0;
                     state_d = RUN;
                  end else begin
                     state_d = RELEASE;
                  end
               end else begin
                  por_d = por_q + 1'b1;
               end
            end
            RELEASE: begin
               if (stg_q == STG_W'(STAGE_DELAY - 1)) begin
                  stg_d = '0;
                  for (int k = 0; k < CH; k++) begin
                     if (IDX_W'(k) == idx_q) rst_d[k] = 1'b0;
                  end
                  if (idx_q == IDX_W'(CH - 1)) state_d = RUN;
                  else                         idx_d   = idx_q + 1'b1;
               end else begin
                  stg_d = stg_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   for (genvar k = 0; k < CH; k++) begin : g_div
      wb_syscon_div #(
         .DIV_WIDTH(DIV_WIDTH)
      ) u_div (
         .clk_i     (clk_i),
         .sync_rst_i(sync_rst_i),
         .hold_i    (rst_d[k]),
         .en_i      (en_i[k]),
         .div_i     (div_i[k*DIV_WIDTH +: DIV_WIDTH]),
         .sync_o    (sync_o[k])
      );
   end

   assign rst_o   = rst_q;
   assign ready_o = ~|rst_q;

`ifdef WBXBC_SYSCON_FORMAL_EN
   int unsigned since_q;

   always_ff @(posedge clk_i) begin
      if (sync_rst_i || soft_rst_i)           since_q <= 0;
      else if (since_q < POR_DELAY)           since_q <= since_q + 1;
   end

   always @(posedge clk_i) begin
      if (!$isunknown(rst_q)) begin
         assert (ready_o == ~|rst_q);
         assert ((sync_o & rst_q) == '0);
         for (int k = 1; k < CH; k++) assert (rst_q[k] || !rst_q[k-1]);
      end
   end

   assert property (@(posedge clk_i) |($past(rst_q) & ~rst_q) |-> since_q >= POR_DELAY);
   cover property (@(posedge clk_i) state_q == RUN);
   cover property (@(posedge clk_i) (state_q == RUN && soft_rst_i) ##1 state_q == POR);
`endif

endmodule

// File: tb/tb_wb_syscon_seq.sv
// Directed bench for wb_syscon_seq with a schedule-based reference model checked every cycle.
module tb_wb_syscon_seq;

   localparam int CH = 4, POR_DELAY = 8, STAGE_DELAY = 2, DIV_WIDTH = 8;

   logic                    clk = 1'b0;
   logic                    sync_rst, soft_rst;
   logic [CH-1:0]           en;
   logic [CH*DIV_WIDTH-1:0] div;
   logic [CH-1:0]           rst_o, sync_o;
   logic                    ready_o;

   int n_cmp = 0;
   int n_err = 0;
   int e;

   wb_syscon_seq #(
      .CH(CH), .POR_DELAY(POR_DELAY), .STAGE_DELAY(STAGE_DELAY), .DIV_WIDTH(DIV_WIDTH)
   ) dut (
      .clk_i     (clk),
      .sync_rst_i(sync_rst),
      .soft_rst_i(soft_rst),
      .en_i      (en),
      .div_i     (div),
      .rst_o     (rst_o),
      .sync_o    (sync_o),
      .ready_o   (ready_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, got, exp);
      end
   endtask

   // Reference model: time since the last reset decides each domain's reset; each divider
   // pulses on first activity and then every div+1 edges, sampling div at each pulse.
   int      since = -1;
   longint  cyc = 0;
   longint  due [CH];
   bit      active [CH];
   logic [CH-1:0] rst_exp, sync_exp;
   logic          ready_exp;

   initial begin
      for (int k = 0; k < CH; k++) begin
         active[k] = 1'b0;
         due[k]    = 0;
      end
      forever begin
         @(posedge clk);
         cyc++;
         if (sync_rst)                  since = -1;
         else if (since < 0 || soft_rst) since = 0;
         else if (since < 100000)       since++;
         for (int k = 0; k < CH; k++) begin
            rst_exp[k] = (since < 0) || (since < POR_DELAY + k*STAGE_DELAY);
            if (rst_exp[k] || !en[k]) begin
               sync_exp[k] = 1'b0;
               active[k]   = 1'b0;
            end else if (!active[k] || cyc == due[k]) begin
               sync_exp[k] = 1'b1;
               active[k]   = 1'b1;
               due[k]      = cyc + longint'(div[k*DIV_WIDTH +: DIV_WIDTH]) + 1;
            end else begin
               sync_exp[k] = 1'b0;
            end
         end
         ready_exp = (since >= 0) && (since >= POR_DELAY + (CH-1)*STAGE_DELAY);
         #1;
         chk("model_rst",   32'(rst_o),   32'(rst_exp));
         chk("model_sync",  32'(sync_o),  32'(sync_exp));
         chk("model_ready", 32'(ready_o), 32'(ready_exp));
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
      e++;
   endtask

   task automatic wait_to(input int n);
      while (e < n) tick();
   endtask

   initial begin
      sync_rst = 1'b1;
      soft_rst = 1'b0;
      en       = 4'b1111;
      div      = '0;
      div[0*DIV_WIDTH +: DIV_WIDTH] = 8'd3;
      div[1*DIV_WIDTH +: DIV_WIDTH] = 8'd3;
      div[2*DIV_WIDTH +: DIV_WIDTH] = 8'd0;
      div[3*DIV_WIDTH +: DIV_WIDTH] = 8'd5;
      e = 0;
      repeat (3) tick();
      chk("reset_rst",   32'(rst_o),   32'hF);
      chk("reset_sync",  32'(sync_o),  32'h0);
      chk("reset_ready", 32'(ready_o), 32'h0);
      sync_rst = 1'b0;
      e = -1;

      wait_to(7);  chk("por_rst_e7", 32'(rst_o), 32'hF);
      wait_to(8);  chk("rel_rst_e8", 32'(rst_o), 32'hE);  chk("s0_e8", 32'(sync_o[0]), 32'h1);
      wait_to(10); chk("rel_rst_e10", 32'(rst_o), 32'hC); chk("s1_e10", 32'(sync_o[1]), 32'h1);
      wait_to(11); chk("s1_e11", 32'(sync_o[1]), 32'h0);  chk("s2_e11", 32'(sync_o[2]), 32'h0);
      wait_to(12); chk("rel_rst_e12", 32'(rst_o), 32'h8); chk("s2_e12", 32'(sync_o[2]), 32'h1);
      wait_to(13); chk("ready_e13", 32'(ready_o), 32'h0); chk("s2_e13", 32'(sync_o[2]), 32'h1);
      wait_to(14); chk("rel_rst_e14", 32'(rst_o), 32'h0); chk("ready_e14", 32'(ready_o), 32'h1);
      chk("s1_e14", 32'(sync_o[1]), 32'h1);
      wait_to(16); chk("s0_e16", 32'(sync_o[0]), 32'h1);
      wait_to(18); chk("s1_e18", 32'(sync_o[1]), 32'h1);
      div[0*DIV_WIDTH +: DIV_WIDTH] = 8'd1;
      wait_to(19); chk("s0_e19", 32'(sync_o[0]), 32'h0);
      wait_to(20); chk("s0_e20", 32'(sync_o[0]), 32'h1);
      wait_to(21); chk("s0_e21", 32'(sync_o[0]), 32'h0);
      wait_to(22); chk("s0_e22", 32'(sync_o[0]), 32'h1);  chk("s1_e22", 32'(sync_o[1]), 32'h1);
      wait_to(24); en[2] = 1'b0;
      wait_to(25); chk("s2_off_e25", 32'(sync_o[2]), 32'h0);

      wait_to(29); soft_rst = 1'b1;
      wait_to(30); soft_rst = 1'b0;
      chk("soft_rst_e30", 32'(rst_o), 32'hF); chk("soft_ready_e30", 32'(ready_o), 32'h0);
      chk("soft_sync_e30", 32'(sync_o), 32'h0);
      wait_to(37); chk("soft_rst_e37", 32'(rst_o), 32'hF);
      wait_to(38); chk("soft_rst_e38", 32'(rst_o), 32'hE);
      wait_to(40); chk("soft_rst_e40", 32'(rst_o), 32'hC);
      wait_to(42); chk("soft_rst_e42", 32'(rst_o), 32'h8);
      wait_to(43); chk("soft_ready_e43", 32'(ready_o), 32'h0);
      wait_to(44); chk("soft_rst_e44", 32'(rst_o), 32'h0); chk("soft_ready_e44", 32'(ready_o), 32'h1);

      wait_to(59); soft_rst = 1'b1;
      wait_to(60); soft_rst = 1'b0;
      wait_to(70); chk("mid_rel_e70", 32'(rst_o), 32'hC);
      sync_rst = 1'b1;
      wait_to(71); chk("hard_rst_e71", 32'(rst_o), 32'hF); chk("hard_sync_e71", 32'(sync_o), 32'h0);
      chk("hard_ready_e71", 32'(ready_o), 32'h0);
      wait_to(75); chk("hold_rst_e75", 32'(rst_o), 32'hF);
      sync_rst = 1'b0;
      wait_to(83); chk("re_rst_e83", 32'(rst_o), 32'hF);
      wait_to(84); chk("re_rst_e84", 32'(rst_o), 32'hE);
      wait_to(90); chk("re_rst_e90", 32'(rst_o), 32'h0); chk("re_ready_e90", 32'(ready_o), 32'h1);
      wait_to(95); en[2] = 1'b1;
      wait_to(96); chk("s2_reen_e96", 32'(sync_o[2]), 32'h1);
      wait_to(97); chk("s2_reen_e97", 32'(sync_o[2]), 32'h1);
      wait_to(110);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
